// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: 3-stage pipelined floating-point multiplier (RNE rounding, flush-to-zero, valid/ready).
// Optional macro FP_MULT_FLAGS_EN adds a registered flags port {invalid, overflow, underflow, inexact}.
module fp_mult_pipe #(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 7,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out
`ifdef FP_MULT_FLAGS_EN
    ,
    output logic [3:0]   flags
`endif
);

    localparam int XW = EXP_W + 2;
    localparam int PW = 2 * (MAN_W + 1);
    localparam logic [XW-1:0] BIAS_X = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic [XW-1:0] EMAX_X = XW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]  QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

    logic en;
    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    logic               sa, sb;
    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   fa, fb;
    logic               a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic               s1_nan_d, s1_inf_d, s1_zero_d;
    logic [XW-1:0]      s1_exp_d;

    assign {sa, ea, fa} = a;
    assign {sb, eb, fb} = b;

    // exp == 0 is treated as zero regardless of the fraction (no subnormal support)
    assign a_zero = (ea == '0);
    assign a_inf  = (ea == '1) && (fa == '0);
    assign a_nan  = (ea == '1) && (fa != '0);
    assign b_zero = (eb == '0);
    assign b_inf  = (eb == '1) && (fb == '0);
    assign b_nan  = (eb == '1) && (fb != '0);

    assign s1_nan_d  = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
    assign s1_inf_d  = ~s1_nan_d & (a_inf | b_inf);
    assign s1_zero_d = ~s1_nan_d & ~s1_inf_d & (a_zero | b_zero);
    assign s1_exp_d  = {2'b00, ea} + {2'b00, eb} - BIAS_X;

    logic               v1_q, s1_sign_q, s1_nan_q, s1_inf_q, s1_zero_q;
    logic [XW-1:0]      s1_exp_q;
    logic [MAN_W:0]     s1_ma_q, s1_mb_q;
    logic               v2_q, s2_sign_q, s2_nan_q, s2_inf_q, s2_zero_q;
    logic [XW-1:0]      s2_exp_q;
    logic [PW-1:0]      s2_prod_q;

    logic               prod_hi, guard, sticky, round_up, ovf, unf;
    logic [PW-2:0]      norm;
    logic [MAN_W-1:0]   frac_t;
    logic [MAN_W:0]     frac_r;
    logic [XW-1:0]      exp_n, exp_f;
    logic [W-1:0]       out_d;

    // Exponent is carried as two's complement in XW bits so underflow shows up as the sign bit.
    always_comb begin
        prod_hi  = s2_prod_q[PW-1];
        norm     = prod_hi ? s2_prod_q[PW-2:0] : {s2_prod_q[PW-3:0], 1'b0};
        frac_t   = norm[PW-2:MAN_W+1];
        guard    = norm[MAN_W];
        sticky   = |norm[MAN_W-1:0];
        exp_n    = s2_exp_q + {{(XW - 1){1'b0}}, prod_hi};
        round_up = guard & (sticky | frac_t[0]);
        frac_r   = {1'b0, frac_t} + {{MAN_W{1'b0}}, round_up};
        exp_f    = exp_n + {{(XW - 1){1'b0}}, frac_r[MAN_W]};
        ovf      = ~exp_f[XW-1] & (exp_f >= EMAX_X);
        unf      = exp_f[XW-1] | (exp_f == '0);

        out_d = {s2_sign_q, exp_f[EXP_W-1:0], frac_r[MAN_W-1:0]};
        if (s2_nan_q) begin
            out_d = QNAN;
        end else if (s2_inf_q) begin
            out_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (s2_zero_q || unf) begin
            out_d = {s2_sign_q, {(EXP_W + MAN_W){1'b0}}};
        end else if (ovf) begin
            out_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_nan_q  <= 1'b0;
            s1_inf_q  <= 1'b0;
            s1_zero_q <= 1'b0;
            s1_exp_q  <= '0;
            s1_ma_q   <= '0;
            s1_mb_q   <= '0;
            v2_q      <= 1'b0;
            s2_sign_q <= 1'b0;
            s2_nan_q  <= 1'b0;
            s2_inf_q  <= 1'b0;
            s2_zero_q <= 1'b0;
            s2_exp_q  <= '0;
            s2_prod_q <= '0;
            out_valid <= 1'b0;
            out       <= '0;
        end else if (en) begin
            v1_q <= in_valid;
            if (in_valid) begin
                s1_sign_q <= sa ^ sb;
                s1_nan_q  <= s1_nan_d;
                s1_inf_q  <= s1_inf_d;
                s1_zero_q <= s1_zero_d;
                s1_exp_q  <= s1_exp_d;
                s1_ma_q   <= {1'b1, fa};
                s1_mb_q   <= {1'b1, fb};
            end
            v2_q <= v1_q;
            if (v1_q) begin
                s2_sign_q <= s1_sign_q;
                s2_nan_q  <= s1_nan_q;
                s2_inf_q  <= s1_inf_q;
                s2_zero_q <= s1_zero_q;
                s2_exp_q  <= s1_exp_q;
                s2_prod_q <= PW'(s1_ma_q) * PW'(s1_mb_q);
            end
            out_valid <= v2_q;
            if (v2_q) begin
                out <= out_d;
            end
        end
    end

`ifdef FP_MULT_FLAGS_EN
    logic       special;
    logic [3:0] flags_d;

    assign special = s2_nan_q | s2_inf_q | s2_zero_q;
    assign flags_d = {s2_nan_q,
                      ~special & ovf,
                      ~special & ~ovf & unf,
                      ~special & (guard | sticky | ovf | unf)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= 4'b0000;
        end else if (en && v2_q) begin
            flags <= flags_d;
        end
    end
`endif

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Self-checking bench for fp_mult_pipe: directed vectors, random streaming against an
// arithmetic reference model, backpressure, mid-flight reset and an fp32 instance.
module tb_fp_mult_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, out;
    logic        in_valid32, in_ready32, out_valid32, out_ready32;
    logic [31:0] a32, b32, out32;
`ifdef FP_MULT_FLAGS_EN
    logic [3:0]  flags, flags32;
`endif

    fp_mult_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .out(out)
`ifdef FP_MULT_FLAGS_EN
        , .flags(flags)
`endif
    );

    fp_mult_pipe #(.EXP_W(8), .MAN_W(23)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .out_valid(out_valid32), .out_ready(out_ready32), .out(out32)
`ifdef FP_MULT_FLAGS_EN
        , .flags(flags32)
`endif
    );

    int          n_chk = 0;
    int          n_err = 0;
    int          n_outc = 0;
    logic [15:0] q_out[$];
    logic [3:0]  q_flg[$];
    logic        held_v = 1'b0;
    logic [15:0] held_out;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Exact product of the significands, then rounded by comparing the dropped remainder to half an ulp.
    function automatic longint unsigned ref_mul(input longint unsigned x, input longint unsigned y,
                                                input int E, input int M, output logic [3:0] fl);
        longint unsigned one, emax, bias, ex, ey, fx, fy, s, p, keep, rem, half;
        longint          e;
        int              top, sh;
        one  = 64'd1;
        emax = (one << E) - 1;
        bias = (one << (E - 1)) - 1;
        s    = ((x >> (E + M)) ^ (y >> (E + M))) & one;
        ex   = (x >> M) & emax;
        ey   = (y >> M) & emax;
        fx   = x & ((one << M) - 1);
        fy   = y & ((one << M) - 1);
        fl   = 4'b0000;
        if ((ex == emax && fx != 0) || (ey == emax && fy != 0) ||
            (ex == emax && ey == 0) || (ey == emax && ex == 0)) begin
            fl = 4'b1000;
            return (emax << M) | (one << (M - 1));
        end
        if (ex == emax || ey == emax) return (s << (E + M)) | (emax << M);
        if (ex == 0 || ey == 0) return s << (E + M);
        p    = ((one << M) | fx) * ((one << M) | fy);
        top  = ((p >> (2 * M + 1)) != 0) ? 2 * M + 1 : 2 * M;
        sh   = top - M;
        keep = p >> sh;
        rem  = p & ((one << sh) - 1);
        half = one << (sh - 1);
        e    = longint'(ex + ey) - longint'(bias) + longint'(top - 2 * M);
        if (rem != 0) fl[0] = 1'b1;
        if (rem > half || (rem == half && keep[0])) keep++;
        if (keep == (one << (M + 1))) begin
            keep = keep >> 1;
            e++;
        end
        if (e >= longint'(emax)) begin
            fl = 4'b0101;
            return (s << (E + M)) | (emax << M);
        end
        if (e <= 0) begin
            fl = 4'b0011;
            return s << (E + M);
        end
        return (s << (E + M)) | (64'(e) << M) | (keep & ((one << M) - 1));
    endfunction

    // One cycle: called just after a negedge with inputs already set; returns at the next negedge.
    task automatic step();
        logic [3:0]  f;
        logic [15:0] e_out;
        logic [3:0]  e_flg;
        #1;
        if (held_v) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_out", out, held_out);
        end
        if (in_valid && in_ready) begin
            q_out.push_back(16'(ref_mul(a, b, 8, 7, f)));
            q_flg.push_back(f);
        end
        if (out_valid && out_ready) begin
            n_outc++;
            if (q_out.size() == 0) begin
                chk("spurious_out", out_valid, 0);
            end else begin
                e_out = q_out.pop_front();
                e_flg = q_flg.pop_front();
                chk("out", out, e_out);
`ifdef FP_MULT_FLAGS_EN
                chk("flags", flags, e_flg);
`endif
            end
        end
        held_v   = out_valid && !out_ready;
        held_out = out;
        @(negedge clk);
    endtask

    task automatic dir_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic [15:0] eo, input logic [3:0] ef);
        int lat;
        a = ta; b = tb_v; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
        chk({tag, "_lat"}, lat, 3);
        chk(tag, out, eo);
`ifdef FP_MULT_FLAGS_EN
        chk({tag, "_flags"}, flags, ef);
`endif
        step();
    endtask

    task automatic dir32(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic [31:0] eo, input logic [3:0] ef);
        int lat;
        a32 = ta; b32 = tb_v; in_valid32 = 1'b1; out_ready32 = 1'b1;
        @(negedge clk);
        in_valid32 = 1'b0;
        lat = 1;
        while (!out_valid32 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, 3);
        chk(tag, out32, eo);
`ifdef FP_MULT_FLAGS_EN
        chk({tag, "_flags"}, flags32, ef);
`endif
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int n;
        in_valid = 1'b0; out_ready = 1'b1;
        n = 0;
        while ((q_out.size() != 0 || out_valid) && n < 30) begin
            step();
            n++;
        end
        chk({tag, "_drained"}, q_out.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] sa_arr[8];
        logic [15:0] sb_arr[8];
        int          sent, cyc, base;
        logic        acc;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        in_valid32 = 1'b0; out_ready32 = 1'b0; a32 = '0; b32 = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_in_ready", in_ready, 1);
`ifdef FP_MULT_FLAGS_EN
        chk("rst_flags", flags, 0);
`endif
        #2 rst_n = 1'b1;
        @(negedge clk);

        dir_op("mul_basic", 16'h3FC0, 16'h4000, 16'h4040, 4'b0000);
        dir_op("mul_neg",   16'hBFC0, 16'h4000, 16'hC040, 4'b0000);
        dir_op("rne_tie",   16'h3F81, 16'h3FC0, 16'h3FC2, 4'b0001);
        dir_op("rne_below", 16'h3F81, 16'h3F81, 16'h3F82, 4'b0001);
        dir_op("inf_zero",  16'h7F80, 16'h0000, 16'h7FC0, 4'b1000);
        dir_op("neg_inf",   16'hFF80, 16'h4000, 16'hFF80, 4'b0000);
        dir_op("nan_in",    16'h7FC1, 16'h3F80, 16'h7FC0, 4'b1000);
        dir_op("neg_zero",  16'h8000, 16'h4000, 16'h8000, 4'b0000);
        dir_op("sub_inf",   16'h0001, 16'h7F80, 16'h7FC0, 4'b1000);
        dir_op("ovf",       16'h7F00, 16'h4000, 16'h7F80, 4'b0101);
        dir_op("unf",       16'h0080, 16'h3F00, 16'h0000, 4'b0011);
        dir_op("rnd_ovf",   16'h7F7F, 16'h3F81, 16'h7F80, 4'b0101);

        // Backpressure: 8 back-to-back pairs with a 4-cycle out_ready drop mid-stream
        for (int i = 0; i < 8; i++) begin
            sa_arr[i] = 16'($urandom);
            sb_arr[i] = 16'($urandom);
            sa_arr[i][14:7] = 8'($urandom_range(110, 144));
            sb_arr[i][14:7] = 8'($urandom_range(110, 144));
        end
        base = n_outc;
        sent = 0;
        cyc  = 0;
        while (sent < 8 && cyc < 100) begin
            out_ready = !(cyc >= 4 && cyc < 8);
            in_valid  = 1'b1;
            a = sa_arr[sent];
            b = sb_arr[sent];
            #1;
            if (!out_ready) chk("stall_in_ready", in_ready, 0);
            acc = in_ready;
            step();
            if (acc) sent++;
            cyc++;
        end
        drain("stall");
        chk("stall_count", n_outc - base, 8);

        // Random traffic with random valid/ready patterns
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 2) != 0) a[14:7] = 8'($urandom_range(100, 154));
            if ($urandom_range(0, 2) != 0) b[14:7] = 8'($urandom_range(100, 154));
            step();
        end
        drain("rand");

        // Reset with three operations in flight
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = 16'h3F80 + 16'(i);
            b = 16'h4000;
            step();
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out", out, 0);
        q_out.delete();
        q_flg.delete();
        held_v = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            chk("no_stale", out_valid, 0);
            step();
        end
        dir_op("post_rst", 16'h3FC0, 16'h4000, 16'h4040, 4'b0000);

        dir32("fp32_mul", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
        dir32("fp32_nan", 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
